ahb_rom_arbiter: RTL and testbench

//  Two-master AHB-Lite arbiter sharing one AHB slave port (boot ROM) between M0 (CPU fetch) and M1 (DMA/debug).

---
 rtl/ahb_pkg.sv | 51 +++++
 rtl/ahb_arb_req_latch.sv | 64 ++++++
 rtl/ahb_rom_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ahb_rom_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the boot-ROM arbiter slice: transfer types,
// responses, burst codes, bus-owner encoding and the packed control bundle.
package ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [2:0] {
    HburstSingle = 3'd0,
    HburstIncr   = 3'd1,
    HburstWrap4  = 3'd2,
    HburstIncr4  = 3'd3,
    HburstWrap8  = 3'd4,
    HburstIncr8  = 3'd5,
    HburstWrap16 = 3'd6,
    HburstIncr16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnM0   = 2'd1,
    OwnM1   = 2'd2
  } owner_e;

  // Address-phase control, excluding the address itself.
  typedef struct packed {
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic       hmastlock;
  } ahb_ctrl_t;

  // NONSEQ or SEQ: a transfer that needs the slave.
  function automatic logic is_xfer(input logic [1:0] htrans);
    return (htrans == HtransNonseq) || (htrans == HtransSeq);
  endfunction

  // SEQ or BUSY: the master is mid-burst and must keep the bus.
  function automatic logic is_burst_cont(input logic [1:0] htrans);
    return (htrans == HtransSeq) || (htrans == HtransBusy);
  endfunction

endpackage

// File: rtl/ahb_arb_req_latch.sv
// Per-master pending-request buffer. Captures an address phase the master
// believes was accepted while another master held the bus, and the write
// data driven in the following cycle, then releases it once replayed.
module ahb_arb_req_latch
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              hready,
  input  logic              granted,
  input  logic              slave_ready,
  input  logic [ADDR_W-1:0] haddr,
  input  ahb_ctrl_t         ctrl,
  input  logic [DATA_W-1:0] hwdata,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_haddr,
  output ahb_ctrl_t         pend_ctrl,
  output logic [DATA_W-1:0] pend_hwdata
);

  logic              valid_q;
  logic [ADDR_W-1:0] haddr_q;
  ahb_ctrl_t         ctrl_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wcap_q;
  logic              capture;
  logic              clear;

  // Only a real transfer that lost arbitration but saw HREADY high is buffered.
  assign capture = hready && !granted && !valid_q && is_xfer(ctrl.htrans);
  assign clear   = granted && valid_q && slave_ready;

  // Pending address/control and the write data of its (stalled) data cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      haddr_q <= '0;
      ctrl_q  <= '0;
      wdata_q <= '0;
      wcap_q  <= 1'b0;
    end else begin
      if (capture) begin
        valid_q <= 1'b1;
        haddr_q <= haddr;
        ctrl_q  <= ctrl;
      end else if (clear) begin
        valid_q <= 1'b0;
      end
      wcap_q <= capture;
      if (wcap_q) begin
        wdata_q <= hwdata;
      end
    end
  end

  assign pend_valid  = valid_q;
  assign pend_haddr  = haddr_q;
  assign pend_ctrl   = ctrl_q;
  assign pend_hwdata = wdata_q;

endmodule

// File: rtl/ahb_rom_arbiter.sv
// Two-master AHB-Lite arbiter in front of the boot ROM (M0 = CPU fetch,
// M1 = DMA/debug). Grants in the same cycle, buffers the losing master's
// address phase and replays it later, and routes data-phase responses back
// to the data-phase owner only.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise M0 wins every tie.
module ahb_rom_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter bit          PARK_M0 = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic              M0_HMASTLOCK,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic [DATA_W-1:0] M0_HRDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic              M1_HMASTLOCK,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [2:0]        S_HBURST,
  output logic              S_HMASTLOCK,
  output logic [DATA_W-1:0] S_HWDATA,
  input  logic [DATA_W-1:0] S_HRDATA,
  input  logic              S_HREADYOUT,
  input  logic              S_HRESP
);

  owner_e            owner_q, downer_q, last_q, grant, park_m;
  logic              dreplay_q, replay, tie_m0, req0, req1;
  ahb_ctrl_t         m0_ctrl, m1_ctrl, sel_ctrl, m0_pend_ctrl, m1_pend_ctrl;
  logic [ADDR_W-1:0] sel_addr, m0_pend_addr, m1_pend_addr;
  logic [DATA_W-1:0] m0_pend_wdata, m1_pend_wdata;
  logic              m0_pend, m1_pend;

  assign m0_ctrl = {M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HMASTLOCK};
  assign m1_ctrl = {M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HMASTLOCK};
  assign req0    = m0_pend || is_xfer(M0_HTRANS);
  assign req1    = m1_pend || is_xfer(M1_HTRANS);
  assign park_m  = PARK_M0 ? OwnM0 : last_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q;  // 0: M0 preferred on a tie, 1: M1 preferred

  // Round-robin pointer steps past whoever wins a NONSEQ address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_q <= 1'b0;
    end else if (S_HREADYOUT && (sel_ctrl.htrans == HtransNonseq)) begin
      rr_q <= (grant == OwnM0);
    end
  end

  assign tie_m0 = !rr_q;
`else
  assign tie_m0 = 1'b1;
`endif

  // Same-cycle grant: bursts and locked sequences keep the bus, else arbitrate.
  always_comb begin
    grant = OwnNone;
    if (owner_q == OwnM0 && (is_burst_cont(M0_HTRANS) || M0_HMASTLOCK)) begin
      grant = OwnM0;
    end else if (owner_q == OwnM1 && (is_burst_cont(M1_HTRANS) || M1_HMASTLOCK)) begin
      grant = OwnM1;
    end else if (req0 && req1) begin
      grant = tie_m0 ? OwnM0 : OwnM1;
    end else if (req0) begin
      grant = OwnM0;
    end else if (req1) begin
      grant = OwnM1;
    end
  end

  // Slave address phase source: pending buffer, live master, or parked idle.
  always_comb begin
    sel_addr = '0;
    sel_ctrl = '0;
    replay   = 1'b0;
    unique case (grant)
      OwnM0: begin
        replay   = m0_pend;
        sel_addr = m0_pend ? m0_pend_addr : M0_HADDR;
        sel_ctrl = m0_pend ? m0_pend_ctrl : m0_ctrl;
      end
      OwnM1: begin
        replay   = m1_pend;
        sel_addr = m1_pend ? m1_pend_addr : M1_HADDR;
        sel_ctrl = m1_pend ? m1_pend_ctrl : m1_ctrl;
      end
      default: begin
        sel_addr = (park_m == OwnM0) ? M0_HADDR :
                   (park_m == OwnM1) ? M1_HADDR : '0;
      end
    endcase
  end

  assign S_HADDR = sel_addr;
  assign {S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HMASTLOCK} = sel_ctrl;

  // Arbiter state, data-phase owner and park history advance on slave ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q   <= OwnNone;
      downer_q  <= OwnNone;
      last_q    <= OwnNone;
      dreplay_q <= 1'b0;
    end else if (S_HREADYOUT) begin
      owner_q   <= grant;
      downer_q  <= is_xfer(sel_ctrl.htrans) ? grant : OwnNone;
      dreplay_q <= replay && is_xfer(sel_ctrl.htrans);
      if (grant != OwnNone) begin
        last_q <= grant;
      end
    end
  end

  // Pending masters stall; masters on the slave follow it; others run free.
  always_comb begin
    M0_HREADY = 1'b1;
    M1_HREADY = 1'b1;
    if (m0_pend) begin
      M0_HREADY = 1'b0;
    end else if (downer_q == OwnM0 || grant == OwnM0) begin
      M0_HREADY = S_HREADYOUT;
    end
    if (m1_pend) begin
      M1_HREADY = 1'b0;
    end else if (downer_q == OwnM1 || grant == OwnM1) begin
      M1_HREADY = S_HREADYOUT;
    end
  end

  // Data-phase routing: read data/response to the owner, write data from it.
  always_comb begin
    M0_HRDATA = (downer_q == OwnM0) ? S_HRDATA : '0;
    M1_HRDATA = (downer_q == OwnM1) ? S_HRDATA : '0;
    M0_HRESP  = (downer_q == OwnM0) ? S_HRESP : HrespOkay;
    M1_HRESP  = (downer_q == OwnM1) ? S_HRESP : HrespOkay;
    unique case (downer_q)
      OwnM0:   S_HWDATA = dreplay_q ? m0_pend_wdata : M0_HWDATA;
      OwnM1:   S_HWDATA = dreplay_q ? m1_pend_wdata : M1_HWDATA;
      default: S_HWDATA = '0;
    endcase
  end

  ahb_arb_req_latch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_m0_latch (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .hready      (M0_HREADY),
    .granted     (grant == OwnM0),
    .slave_ready (S_HREADYOUT),
    .haddr       (M0_HADDR),
    .ctrl        (m0_ctrl),
    .hwdata      (M0_HWDATA),
    .pend_valid  (m0_pend),
    .pend_haddr  (m0_pend_addr),
    .pend_ctrl   (m0_pend_ctrl),
    .pend_hwdata (m0_pend_wdata)
  );

  ahb_arb_req_latch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_m1_latch (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .hready      (M1_HREADY),
    .granted     (grant == OwnM1),
    .slave_ready (S_HREADYOUT),
    .haddr       (M1_HADDR),
    .ctrl        (m1_ctrl),
    .hwdata      (M1_HWDATA),
    .pend_valid  (m1_pend),
    .pend_haddr  (m1_pend_addr),
    .pend_ctrl   (m1_pend_ctrl),
    .pend_hwdata (m1_pend_wdata)
  );

endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Directed bench for ahb_rom_arbiter with a one-cycle ROM slave model that
// returns rom[w] = 0x1000_0000 + w on reads and ERROR on writes.
module tb_ahb_rom_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [1:0] TIdle   = 2'b00;
  localparam logic [1:0] TNonseq = 2'b10;
  localparam logic [1:0] TSeq    = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] M0_HADDR, M1_HADDR, S_HADDR;
  logic [1:0]    M0_HTRANS, M1_HTRANS, S_HTRANS;
  logic          M0_HWRITE, M1_HWRITE, S_HWRITE;
  logic [2:0]    M0_HSIZE, M1_HSIZE, S_HSIZE;
  logic [2:0]    M0_HBURST, M1_HBURST, S_HBURST;
  logic          M0_HMASTLOCK, M1_HMASTLOCK, S_HMASTLOCK;
  logic [DW-1:0] M0_HWDATA, M1_HWDATA, S_HWDATA;
  logic [DW-1:0] M0_HRDATA, M1_HRDATA, S_HRDATA;
  logic          M0_HREADY, M1_HREADY, S_HREADYOUT;
  logic          M0_HRESP, M1_HRESP, S_HRESP;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_rom_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HMASTLOCK(M0_HMASTLOCK),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY),
    .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HMASTLOCK(M1_HMASTLOCK),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY),
    .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP)
  );

  // ROM slave: zero wait states, data phase registered from the address phase.
  logic          d_valid, d_write;
  logic [AW-1:0] d_addr;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] addr);
    return 32'h1000_0000 + {2'b00, addr[AW-1:2]};
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_addr  <= '0;
    end else if (S_HREADYOUT) begin
      d_valid <= S_HTRANS[1];
      d_write <= S_HWRITE;
      d_addr  <= S_HADDR;
    end
  end

  assign S_HREADYOUT = 1'b1;
  assign S_HRDATA    = (d_valid && !d_write) ? rom_word(d_addr) : '0;
  assign S_HRESP     = d_valid && d_write;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_m0();
    M0_HADDR = '0; M0_HTRANS = TIdle; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2;
    M0_HBURST = 3'd0; M0_HMASTLOCK = 1'b0; M0_HWDATA = '0;
  endtask

  task automatic idle_m1();
    M1_HADDR = '0; M1_HTRANS = TIdle; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2;
    M1_HBURST = 3'd0; M1_HMASTLOCK = 1'b0; M1_HWDATA = '0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    idle_m0();
    idle_m1();
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  logic [31:0] got4 [8];
  logic [31:0] exp4 [8];
  int          n4, i0, i1;
  logic        h0, h1, seen;

  initial begin
    // Reset values
    HRESETn = 1'b0;
    idle_m0();
    idle_m1();
    @(negedge HCLK);
    check("rst_m0_hready", M0_HREADY, 1);
    check("rst_m1_hready", M1_HREADY, 1);
    check("rst_m0_hrdata", M0_HRDATA, 0);
    check("rst_m1_hresp", M1_HRESP, 0);
    check("rst_s_htrans", S_HTRANS, 0);
    check("rst_s_haddr", S_HADDR, 0);

    // 1: M0 single read, zero added wait states
    do_reset();
    M0_HADDR = 32'h10; M0_HTRANS = TNonseq;
    @(negedge HCLK);
    check("t1_s_haddr", S_HADDR, 32'h10);
    check("t1_s_htrans", S_HTRANS, TNonseq);
    check("t1_m0_hready_a", M0_HREADY, 1);
    tick();
    idle_m0();
    @(negedge HCLK);
    check("t1_m0_hrdata", M0_HRDATA, 32'h1000_0004);
    check("t1_m0_hready_d", M0_HREADY, 1);
    check("t1_m1_hrdata", M1_HRDATA, 0);

    // 2: simultaneous NONSEQ, M0 wins, M1 replayed next cycle
    do_reset();
    M0_HADDR = 32'h100; M0_HTRANS = TNonseq;
    M1_HADDR = 32'h200; M1_HTRANS = TNonseq;
    @(negedge HCLK);
    check("t2_s_haddr_t", S_HADDR, 32'h100);
    check("t2_m1_hready_t", M1_HREADY, 1);
    tick();
    idle_m0();
    idle_m1();
    @(negedge HCLK);
    check("t2_m0_hrdata", M0_HRDATA, 32'h1000_0040);
    check("t2_s_haddr_t1", S_HADDR, 32'h200);
    check("t2_m1_hready_t1", M1_HREADY, 0);
    tick();
    @(negedge HCLK);
    check("t2_m1_hrdata", M1_HRDATA, 32'h1000_0080);
    check("t2_m1_hready_t2", M1_HREADY, 1);
    check("t2_m0_hrdata_t2", M0_HRDATA, 0);

    // 3: M0 INCR4 is not interrupted by M1
    do_reset();
    M0_HADDR = 32'h0; M0_HTRANS = TNonseq; M0_HBURST = 3'd3;
    @(negedge HCLK);
    check("t3_beat0", S_HADDR, 32'h0);
    tick();
    M0_HADDR = 32'h4; M0_HTRANS = TSeq;
    M1_HADDR = 32'h300; M1_HTRANS = TNonseq;
    @(negedge HCLK);
    check("t3_beat1", S_HADDR, 32'h4);
    check("t3_m1_hready_b1", M1_HREADY, 1);
    tick();
    M0_HADDR = 32'h8;
    idle_m1();
    @(negedge HCLK);
    check("t3_beat2", S_HADDR, 32'h8);
    check("t3_m1_hready_b2", M1_HREADY, 0);
    tick();
    M0_HADDR = 32'hC;
    @(negedge HCLK);
    check("t3_beat3", S_HADDR, 32'hC);
    check("t3_m1_hready_b3", M1_HREADY, 0);
    tick();
    idle_m0();
    @(negedge HCLK);
    check("t3_m1_addr", S_HADDR, 32'h300);
    check("t3_m1_hready_r", M1_HREADY, 0);
    tick();
    @(negedge HCLK);
    check("t3_m1_hready_d", M1_HREADY, 1);
    check("t3_m1_hrdata", M1_HRDATA, 32'h1000_00C0);

    // 5: M1 write errors, M0 read unaffected
    do_reset();
    M0_HADDR = 32'h80; M0_HTRANS = TNonseq;
    M1_HADDR = 32'h40; M1_HTRANS = TNonseq; M1_HWRITE = 1'b1;
    @(negedge HCLK);
    check("t5_s_haddr_t", S_HADDR, 32'h80);
    check("t5_m1_hready_t", M1_HREADY, 1);
    tick();
    idle_m0();
    idle_m1();
    M1_HWDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    check("t5_s_haddr_t1", S_HADDR, 32'h40);
    check("t5_s_hwrite_t1", S_HWRITE, 1);
    check("t5_m0_hrdata", M0_HRDATA, 32'h1000_0020);
    check("t5_m0_hresp_t1", M0_HRESP, 0);
    check("t5_m1_hresp_t1", M1_HRESP, 0);
    check("t5_m1_hready_t1", M1_HREADY, 0);
    tick();
    @(negedge HCLK);
    check("t5_m1_hresp", M1_HRESP, 1);
    check("t5_m1_hready_t2", M1_HREADY, 1);
    check("t5_m0_hresp_t2", M0_HRESP, 0);
    check("t5_s_hwdata", S_HWDATA, 32'hDEAD_BEEF);

    // 4: four contended singles from each master
`ifdef ARB_ROUND_ROBIN_EN
    exp4[0] = 32'h400; exp4[1] = 32'h500; exp4[2] = 32'h404; exp4[3] = 32'h504;
    exp4[4] = 32'h408; exp4[5] = 32'h508; exp4[6] = 32'h40C; exp4[7] = 32'h50C;
`else
    exp4[0] = 32'h400; exp4[1] = 32'h404; exp4[2] = 32'h408; exp4[3] = 32'h40C;
    exp4[4] = 32'h500; exp4[5] = 32'h504; exp4[6] = 32'h508; exp4[7] = 32'h50C;
`endif
    do_reset();
    n4 = 0; i0 = 0; i1 = 0;
    for (int cyc = 0; cyc < 40 && n4 < 8; cyc++) begin
      M0_HTRANS = (i0 < 4) ? TNonseq : TIdle;
      M0_HADDR  = 32'h400 + 32'(4 * i0);
      M1_HTRANS = (i1 < 4) ? TNonseq : TIdle;
      M1_HADDR  = 32'h500 + 32'(4 * i1);
      @(negedge HCLK);
      if (S_HTRANS == TNonseq) begin
        got4[n4] = S_HADDR;
        n4++;
      end
      h0 = M0_HREADY;
      h1 = M1_HREADY;
      tick();
      if (h0 && i0 < 4) i0++;
      if (h1 && i1 < 4) i1++;
    end
    check("t4_grant_count", n4, 8);
    for (int k = 0; k < 8; k++) begin
      if (k < n4) check($sformatf("t4_grant%0d", k), got4[k], exp4[k]);
    end
    idle_m0();
    idle_m1();

    // 6: reset while M1 is pending discards the buffered request
    do_reset();
    M0_HADDR = 32'h0; M0_HTRANS = TNonseq; M0_HBURST = 3'd3;
    tick();
    M0_HADDR = 32'h4; M0_HTRANS = TSeq;
    M1_HADDR = 32'h200; M1_HTRANS = TNonseq;
    tick();
    M0_HADDR = 32'h8;
    idle_m1();
    @(negedge HCLK);
    check("t6_m1_pending", M1_HREADY, 0);
    tick();
    HRESETn = 1'b0;
    idle_m0();
    idle_m1();
    @(negedge HCLK);
    check("t6_rst_m1_hready", M1_HREADY, 1);
    check("t6_rst_m0_hready", M0_HREADY, 1);
    check("t6_rst_m0_hrdata", M0_HRDATA, 0);
    check("t6_rst_m1_hresp", M1_HRESP, 0);
    check("t6_rst_s_htrans", S_HTRANS, 0);
    check("t6_rst_s_haddr", S_HADDR, 0);
    tick();
    HRESETn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge HCLK);
      if (S_HTRANS != TIdle || S_HADDR == 32'h200 || !M1_HREADY) seen = 1'b1;
      tick();
    end
    check("t6_no_replay", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
